// File: rtl/b_weight_loader.sv
// B-operand column loader: streams ROWS words into the PE column's shadow bank, flags a full tile, swaps banks on request.
// One edge from acceptance to out_B/B_EN; b_ready is low outside LOAD, during zero padding and whenever EN is low. Option: BLOAD_ZERO_PAD_EN.
module b_weight_loader #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  input  logic              swap_req,
  output logic [DATA_W-1:0] out_B,
  output logic              B_EN,
  output logic              SELECTOR,
  output logic              bank_full,
  output logic              swap_err
);

  localparam int CW = $clog2(ROWS) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          pad;
  logic          acc;
  logic          shift;
  logic          last_word;

  always_comb begin
    b_ready   = EN && (state == LOAD) && !pad;
    acc       = b_valid && b_ready;
    shift     = acc || (EN && (state == LOAD) && pad);
    last_word = shift && (cnt == CW'(ROWS - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (EN) state_nxt = LOAD;
      LOAD:    if (last_word) state_nxt = FULL;
      FULL:    if (EN && swap_req) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt       <= '0;
      out_B     <= '0;
      B_EN      <= 1'b0;
      SELECTOR  <= 1'b0;
      bank_full <= 1'b0;
      swap_err  <= 1'b0;
    end else begin
      B_EN <= shift;
      if (shift) begin
        // padding words shift zeros so the deepest rows of a short tile stay clean
        out_B <= acc ? b_data : '0;
        cnt   <= last_word ? '0 : cnt + 1'b1;
      end
      if (last_word) bank_full <= 1'b1;
      if (EN && swap_req) begin
        if (state == FULL) begin
          SELECTOR  <= ~SELECTOR;
          bank_full <= 1'b0;
        end else begin
          swap_err  <= 1'b1;
        end
      end
    end
  end

`ifdef BLOAD_ZERO_PAD_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                                        pad <= 1'b0;
    else if (acc && b_last && cnt != CW'(ROWS - 1))    pad <= 1'b1;
    else if (last_word)                                pad <= 1'b0;
  end
`else
  logic unused_b_last;
  assign unused_b_last = b_last;
  assign pad           = 1'b0;
`endif

endmodule

// File: tb/tb_b_weight_loader.sv
// Directed table-driven bench for b_weight_loader (ROWS=4), plus async-reset and short-tile sequences.
module tb_b_weight_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        EN;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;
  logic        b_last;
  logic        swap_req;
  logic [31:0] out_B;
  logic        B_EN;
  logic        SELECTOR;
  logic        bank_full;
  logic        swap_err;

  int checks = 0;
  int errors = 0;

  b_weight_loader #(.ROWS(4), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .b_valid(b_valid), .b_ready(b_ready),
    .b_data(b_data), .b_last(b_last), .swap_req(swap_req), .out_B(out_B),
    .B_EN(B_EN), .SELECTOR(SELECTOR), .bank_full(bank_full), .swap_err(swap_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        en, vld, last, swp;
    logic [31:0] dat;
    logic        rdy, ben, sel, full, err;
    logic [31:0] ob;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic vld, input logic [31:0] dat,
                              input logic last, input logic swp, input logic rdy,
                              input logic [31:0] ob, input logic ben, input logic sel,
                              input logic full, input logic err);
    vec_t v;
    v.en = en; v.vld = vld; v.dat = dat; v.last = last; v.swp = swp;
    v.rdy = rdy; v.ob = ob; v.ben = ben; v.sel = sel; v.full = full; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input vec_t v);
    chk("b_ready",   idx, 32'(b_ready),   32'(v.rdy));
    chk("out_B",     idx, out_B,          v.ob);
    chk("B_EN",      idx, 32'(B_EN),      32'(v.ben));
    chk("SELECTOR",  idx, 32'(SELECTOR),  32'(v.sel));
    chk("bank_full", idx, 32'(bank_full), 32'(v.full));
    chk("swap_err",  idx, 32'(swap_err),  32'(v.err));
  endtask

  // inputs held for one cycle, outputs checked 1 time unit after the edge
  task automatic step(input int idx, input vec_t v);
    EN = v.en; b_valid = v.vld; b_data = v.dat; b_last = v.last; swap_req = v.swp;
    @(posedge CLK);
    #1;
    check_outs(idx, v);
  endtask

  initial begin
    vec_t hs[$];
    RESET = 1'b0; EN = 1'b0; b_valid = 1'b0; b_data = '0; b_last = 1'b0; swap_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_outs(-1, mk(0,0,0,0,0, 0,32'h0,0,0,0,0));
    RESET = 1'b1;

    //            en vld data          lst swp  rdy out_B        ben sel full err
    tbl.push_back(mk(1,0,32'h0,        0,0,     1,32'h0,        0,0,0,0)); // IDLE -> LOAD
    tbl.push_back(mk(1,1,32'h11,       0,0,     1,32'h11,       1,0,0,0));
    tbl.push_back(mk(1,1,32'h22,       0,0,     1,32'h22,       1,0,0,0));
    tbl.push_back(mk(1,1,32'h33,       0,0,     1,32'h33,       1,0,0,0));
    tbl.push_back(mk(1,1,32'h44,       0,0,     0,32'h44,       1,0,1,0)); // FULL
    tbl.push_back(mk(1,0,32'h0,        0,1,     1,32'h44,       0,1,0,0)); // swap in first FULL cycle
    tbl.push_back(mk(1,1,32'hA,        0,0,     1,32'hA,        1,1,0,0));
    tbl.push_back(mk(1,1,32'hB,        0,0,     1,32'hB,        1,1,0,0));
    tbl.push_back(mk(1,1,32'hC,        0,0,     1,32'hC,        1,1,0,0));
    tbl.push_back(mk(1,1,32'hD,        0,0,     0,32'hD,        1,1,1,0));
    tbl.push_back(mk(1,0,32'h0,        0,1,     1,32'hD,        0,0,0,0)); // swap back
    tbl.push_back(mk(1,1,32'h101,      0,0,     1,32'h101,      1,0,0,0)); // bubbles
    tbl.push_back(mk(1,0,32'hDEAD,     0,0,     1,32'h101,      0,0,0,0));
    tbl.push_back(mk(1,1,32'h102,      0,0,     1,32'h102,      1,0,0,0));
    tbl.push_back(mk(1,0,32'hDEAD,     0,0,     1,32'h102,      0,0,0,0));
    tbl.push_back(mk(1,1,32'h103,      0,0,     1,32'h103,      1,0,0,0));
    tbl.push_back(mk(1,0,32'hDEAD,     0,0,     1,32'h103,      0,0,0,0));
    tbl.push_back(mk(1,1,32'h104,      0,0,     0,32'h104,      1,0,1,0));
    tbl.push_back(mk(1,1,32'hBAD,      0,0,     0,32'h104,      0,0,1,0)); // held in FULL
    tbl.push_back(mk(1,0,32'h0,        0,1,     1,32'h104,      0,1,0,0));
    tbl.push_back(mk(1,1,32'h201,      0,0,     1,32'h201,      1,1,0,0)); // early swap
    tbl.push_back(mk(1,1,32'h202,      0,0,     1,32'h202,      1,1,0,0));
    tbl.push_back(mk(1,0,32'h0,        0,1,     1,32'h202,      0,1,0,1));
    tbl.push_back(mk(1,1,32'h203,      0,0,     1,32'h203,      1,1,0,1));
    tbl.push_back(mk(1,1,32'h204,      0,0,     0,32'h204,      1,1,1,1));
    tbl.push_back(mk(1,0,32'h0,        0,1,     1,32'h204,      0,0,0,1));
    tbl.push_back(mk(1,1,32'h301,      0,0,     1,32'h301,      1,0,0,1)); // EN freeze
    tbl.push_back(mk(1,1,32'h302,      0,0,     1,32'h302,      1,0,0,1));
    tbl.push_back(mk(0,1,32'h999,      0,1,     0,32'h302,      0,0,0,1));
    tbl.push_back(mk(0,1,32'h999,      0,1,     0,32'h302,      0,0,0,1));
    tbl.push_back(mk(0,1,32'h999,      0,1,     0,32'h302,      0,0,0,1));
    tbl.push_back(mk(1,1,32'h303,      0,0,     1,32'h303,      1,0,0,1));
    tbl.push_back(mk(1,1,32'h304,      0,0,     0,32'h304,      1,0,1,1));
    tbl.push_back(mk(0,0,32'h0,        0,1,     0,32'h304,      0,0,1,1)); // swap ignored when EN=0
    tbl.push_back(mk(1,0,32'h0,        0,1,     1,32'h304,      0,1,0,1));
    tbl.push_back(mk(1,1,32'h401,      0,0,     1,32'h401,      1,1,0,1));
    tbl.push_back(mk(1,1,32'h402,      0,0,     1,32'h402,      1,1,0,1));

    for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

    // asynchronous reset mid-tile, between edges
    #2;
    RESET = 1'b0;
    #1;
    check_outs(100, mk(1,1,32'h402,0,0, 0,32'h0,0,0,0,0));
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    // partial tile discarded; swap in IDLE raises error; short-tile handling
    hs.push_back(mk(1,0,32'h0,  0,1, 1,32'h0,  0,0,0,1));
    hs.push_back(mk(1,1,32'h55, 0,0, 1,32'h55, 1,0,0,1));
`ifdef BLOAD_ZERO_PAD_EN
    hs.push_back(mk(1,1,32'h66, 1,0, 0,32'h66, 1,0,0,1));
    hs.push_back(mk(1,1,32'h77, 0,0, 0,32'h0,  1,0,0,1));
    hs.push_back(mk(1,1,32'h78, 0,0, 0,32'h0,  1,0,1,1));
    hs.push_back(mk(1,0,32'h0,  0,1, 1,32'h0,  0,1,0,1));
`else
    hs.push_back(mk(1,1,32'h66, 1,0, 1,32'h66, 1,0,0,1));
    hs.push_back(mk(1,1,32'h77, 1,0, 1,32'h77, 1,0,0,1));
    hs.push_back(mk(1,1,32'h88, 0,0, 0,32'h88, 1,0,1,1));
    hs.push_back(mk(1,0,32'h0,  0,1, 1,32'h88, 0,1,0,1));
`endif
    for (int i = 0; i < hs.size(); i++) step(200 + i, hs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
